// File: rtl/control_unit_fsm.sv
// Self-sequencing control unit: latches an instruction on run, steps IDLE->T1[->T2->T3],
// and drives registered Moore strobes for the register file, bus mux and ALU.
module control_unit_fsm #(
  parameter  int REG_W    = 3,
  parameter  int IW       = 16,
  parameter  int CNT_W    = 8,
  localparam int NUM_REGS = 2**REG_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                run,
  input  logic [IW-1:0]       instruction,
  output logic [REG_W:0]      mux_select,
  output logic [NUM_REGS-1:0] regs_write_enable,
  output logic [1:0]          alu_op,
  output logic                reg_A_enable,
  output logic                reg_R_enable,
  output logic                out_enable,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    retired_count
);

  if (IW < 3 + 2*REG_W) begin : g_bad_iw
    $error("control_unit_fsm: IW too small for opcode plus two register fields");
  end

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NAN = 3'b010;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_REP = 3'b111;

  localparam logic [REG_W:0] MUX_NONE = '1;
  localparam logic [REG_W:0] MUX_DIN  = {1'b1, {REG_W{1'b0}}};
  localparam logic [REG_W:0] MUX_G    = {1'b1, REG_W'(1)};

  typedef struct packed {
    logic [REG_W:0]      mux;
    logic [NUM_REGS-1:0] we;
    logic [1:0]          alu;
    logic                a_en;
    logic                r_en;
    logic                o_en;
    logic                done;
  } out_t;

  localparam out_t OUT_IDLE = '{mux: MUX_NONE, we: '0, alu: 2'b11,
                                a_en: 1'b0, r_en: 1'b0, o_en: 1'b0, done: 1'b0};

  // Strobes for the step the machine is about to enter; registered so they are glitch-free.
  function automatic out_t f_decode(input state_t st, input logic [2:0] op,
                                    input logic [REG_W-1:0] rx, input logic [REG_W-1:0] ry);
    out_t o;
    logic [NUM_REGS-1:0] w_rx_oh;
    o       = OUT_IDLE;
    w_rx_oh = NUM_REGS'(1) << rx;
    case (st)
      S_T1: begin
        case (op)
          OP_ADD, OP_SUB, OP_NAN: begin
            o.mux  = {1'b0, rx};
            o.a_en = 1'b1;
            o.alu  = op[1:0];
          end
          OP_LDI: begin
            o.mux  = MUX_DIN;
            o.we   = w_rx_oh;
            o.done = 1'b1;
          end
          OP_REP: begin
            o.mux  = {1'b0, ry};
            o.we   = w_rx_oh;
            o.done = 1'b1;
          end
          OP_OUT: begin
            o.mux  = {1'b0, rx};
            o.o_en = 1'b1;
            o.done = 1'b1;
          end
          default: o.done = 1'b1;
        endcase
      end
      S_T2: begin
        o.mux  = {1'b0, ry};
        o.r_en = 1'b1;
        o.alu  = op[1:0];
      end
      S_T3: begin
        o.mux  = MUX_G;
        o.we   = w_rx_oh;
        o.alu  = op[1:0];
        o.done = 1'b1;
      end
      default: o = OUT_IDLE;
    endcase
    return o;
  endfunction

  state_t             r_state;
  logic [IW-1:0]      r_ir;
  out_t               r_out;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nx;
  logic [IW-1:0]      w_ir_nx;
  logic               w_issue;
  logic [2:0]         w_op_nx;
  logic [REG_W-1:0]   w_rx_nx;
  logic [REG_W-1:0]   w_ry_nx;

  if (IW > 3 + 2*REG_W) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^r_ir[IW-4-2*REG_W:0];
  end

  assign w_issue = run & ((r_state == S_IDLE) | r_out.done);
  assign w_ir_nx = w_issue ? instruction : r_ir;
  assign w_op_nx = w_ir_nx[IW-1 -: 3];
  assign w_rx_nx = w_ir_nx[IW-4 -: REG_W];
  assign w_ry_nx = w_ir_nx[IW-4-REG_W -: REG_W];

  // The final step of any instruction doubles as an issue slot for back-to-back runs.
  always_comb begin
    w_state_nx = S_IDLE;
    if (r_state == S_IDLE || r_out.done) begin
      w_state_nx = run ? S_T1 : S_IDLE;
    end else begin
      case (r_state)
        S_T1:    w_state_nx = S_T2;
        S_T2:    w_state_nx = S_T3;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_out   <= OUT_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ir    <= w_ir_nx;
      r_out   <= f_decode(w_state_nx, w_op_nx, w_rx_nx, w_ry_nx);
      if (r_out.done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign mux_select        = r_out.mux;
  assign regs_write_enable = r_out.we;
  assign alu_op            = r_out.alu;
  assign reg_A_enable      = r_out.a_en;
  assign reg_R_enable      = r_out.r_en;
  assign out_enable        = r_out.o_en;
  assign done              = r_out.done;
  assign busy              = (r_state != S_IDLE);
  assign retired_count     = r_cnt;

endmodule
